pwm_breathe_multi: RTL and testbench

- Multi-channel PWM generator with a shared period counter and per-channel duty engines.
- Each channel runs in one of four modes: static, sawtooth ramp, triangle "breathing" ramp, or off.
- Period, step, modes and duties are double-buffered and take effect only at a period boundary, so there are no glitched cycles.
- Reset defaults reproduce the 0..100 step-5 breathing LED behaviour on every channel.

---
 rtl/pwm_breathe_multi.sv | 190 +++++++++++++++++++
 tb/tb_pwm_breathe_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breathe_multi.sv
// Multi-channel PWM with a shared period counter and per-channel duty engines.
// Ports: clk, rst (async, active high), en, period_in, step_in, mode_in,
//   duty_in, load (shadow capture strobe) -> dout, duty_out, cyc_end, pending.
module pwm_breathe_multi #(
  parameter int CH         = 4,
  parameter int CW         = 8,
  parameter int RST_PERIOD = 100,
  parameter int RST_STEP   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CW-1:0]    period_in,
  input  logic [CW-1:0]    step_in,
  input  logic [2*CH-1:0]  mode_in,
  input  logic [CW*CH-1:0] duty_in,
  input  logic             load,
  output logic [CH-1:0]    dout,
  output logic [CW*CH-1:0] duty_out,
  output logic             cyc_end,
  output logic             pending
);

  localparam logic [CW-1:0]   RP  = CW'(RST_PERIOD);
  localparam logic [CW-1:0]   RS  = CW'(RST_STEP);
  localparam logic [2*CH-1:0] RM  = {CH{2'b10}};
  localparam logic [CW-1:0]   ONE = CW'(1);
  localparam logic [CW-1:0]   TWO = CW'(2);

  localparam logic [1:0] M_SAW = 2'b01;
  localparam logic [1:0] M_TRI = 2'b10;
  localparam logic [1:0] M_OFF = 2'b11;

  // active configuration
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    per_q, per_d;
  logic [CW-1:0]    stp_q, stp_d;
  logic [2*CH-1:0]  mode_q, mode_d;
  logic [CW-1:0]    duty_q [CH];
  logic [CW-1:0]    duty_d [CH];
  logic [CH-1:0]    up_q, up_d;

  // shadow configuration
  logic [CW-1:0]    sper_q, sper_d;
  logic [CW-1:0]    sstp_q, sstp_d;
  logic [2*CH-1:0]  smode_q, smode_d;
  logic [CW*CH-1:0] sduty_q, sduty_d;

  logic             pend_q, pend_d;
  logic [CH-1:0]    dout_q, dout_d;
  logic             cyc_q, cyc_d;

  logic             run;
  logic             bnd;
  logic             apply;

  // One ramp step for a channel; returns {next_up, next_duty}.
  // Sums are CW+1 bits wide so d+s never wraps.
  function automatic logic [CW:0] ramp_f(
    input logic [1:0]    m,
    input logic          up,
    input logic [CW-1:0] d,
    input logic [CW-1:0] s,
    input logic [CW-1:0] p
  );
    logic [CW:0]   sum;
    logic          nup;
    logic [CW-1:0] nd;
    sum = {1'b0, d} + {1'b0, s};
    nup = up;
    nd  = d;
    if (s != '0) begin
      case (m)
        M_SAW: begin
          if (sum > {1'b0, p}) nd = '0;
          else                 nd = sum[CW-1:0];
        end
        M_TRI: begin
          if (up) begin
            if (sum >= {1'b0, p}) begin
              nd  = p;
              nup = 1'b0;
            end else begin
              nd  = sum[CW-1:0];
            end
          end else begin
            if (d <= s) begin
              nd  = '0;
              nup = 1'b1;
            end else begin
              nd  = d - s;
            end
          end
        end
        default: ;
      endcase
    end
    return {nup, nd};
  endfunction

  assign run = en && (per_q >= TWO);
  assign bnd = run && (cnt_q == per_q - ONE);
  // While stopped or with an invalid period every edge acts as a boundary
  // for applying the shadow, so a fixing load is never stranded.
  assign apply = pend_q && (bnd || !run);

  always_comb begin
    cnt_d   = (run && !bnd) ? cnt_q + ONE : '0;
    cyc_d   = bnd;
    per_d   = per_q;
    stp_d   = stp_q;
    mode_d  = mode_q;
    up_d    = up_q;
    sper_d  = sper_q;
    sstp_d  = sstp_q;
    smode_d = smode_q;
    sduty_d = sduty_q;
    dout_d  = '0;
    for (int i = 0; i < CH; i++) begin
      duty_d[i] = duty_q[i];
      dout_d[i] = run && (mode_q[2*i +: 2] != M_OFF)
                  && (cnt_q < duty_q[i]);
    end

    if (load) begin
      sper_d  = period_in;
      sstp_d  = step_in;
      smode_d = mode_in;
      sduty_d = duty_in;
    end
    // a load on the applying edge re-arms pending for the next boundary
    pend_d = apply ? load : (pend_q | load);

    if (apply) begin
      per_d  = sper_q;
      stp_d  = sstp_q;
      mode_d = smode_q;
      up_d   = '1;
      for (int i = 0; i < CH; i++)
        duty_d[i] = sduty_q[CW*i +: CW];
    end else if (bnd) begin
      for (int i = 0; i < CH; i++)
        {up_d[i], duty_d[i]} = ramp_f(mode_q[2*i +: 2], up_q[i],
                                      duty_q[i], stp_q, per_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      per_q   <= RP;
      stp_q   <= RS;
      mode_q  <= RM;
      up_q    <= '1;
      sper_q  <= RP;
      sstp_q  <= RS;
      smode_q <= RM;
      sduty_q <= '0;
      pend_q  <= 1'b0;
      dout_q  <= '0;
      cyc_q   <= 1'b0;
      for (int i = 0; i < CH; i++)
        duty_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      stp_q   <= stp_d;
      mode_q  <= mode_d;
      up_q    <= up_d;
      sper_q  <= sper_d;
      sstp_q  <= sstp_d;
      smode_q <= smode_d;
      sduty_q <= sduty_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      cyc_q   <= cyc_d;
      for (int i = 0; i < CH; i++)
        duty_q[i] <= duty_d[i];
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_dout
    assign duty_out[CW*g +: CW] = duty_q[g];
  end

  assign dout    = dout_q;
  assign cyc_end = cyc_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Directed bench for pwm_breathe_multi: breathing defaults, static/saw
// modes, double-buffered loads, enable, invalid period and async reset.
module tb_pwm_breathe_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  period_in;
  logic [7:0]  step_in;
  logic [7:0]  mode_in;
  logic [31:0] duty_in;
  logic        load;
  logic [3:0]  dout;
  logic [31:0] duty_out;
  logic        cyc_end;
  logic        pending;

  int n_chk;
  int n_fail;

  int          hi [4];
  int          len;
  logic [31:0] dstart;
  logic        pend_start;
  logic        pend_mid;
  logic        pend_end;
  int          bad;
  int          dexp;

  pwm_breathe_multi #(
    .CH(4), .CW(8), .RST_PERIOD(100), .RST_STEP(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .period_in(period_in), .step_in(step_in),
    .mode_in(mode_in), .duty_in(duty_in), .load(load),
    .dout(dout), .duty_out(duty_out),
    .cyc_end(cyc_end), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Measures one period starting with cnt=0; ld_at pulses load on the
  // edge where cnt equals ld_at (-1: no load).
  task automatic measure(input int ld_at);
    bit done;
    done = 0;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    len = 0;
    pend_mid = 1'b0;
    load = (ld_at == 0);
    while (!done && len < 300) begin
      @(negedge clk);
      if (len == 0) begin
        dstart     = duty_out;
        pend_start = pending;
      end
      for (int c = 0; c < 4; c++) if (dout[c]) hi[c]++;
      if (len == 45) pend_mid = pending;
      len++;
      load = (ld_at == len);
      if (cyc_end) done = 1;
    end
    load = 1'b0;
    pend_end = pending;
    if (!done) check("period_timeout", 0, 1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    period_in = 8'd100;
    step_in = 8'd5;
    mode_in = 8'b10101010;
    duty_in = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", 32'(dout), 0);
    check("rst_cyc", 32'(cyc_end), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_duty", duty_out, 0);

    // breathing defaults
    rst = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 42; k++) begin
      if (k <= 20)      dexp = 5 * k;
      else if (k <= 40) dexp = 100 - 5 * (k - 20);
      else              dexp = 5 * (k - 40);
      measure(-1);
      check("tri_len", len, 100);
      check("tri_hi0", hi[0], dexp);
      check("tri_duty0", 32'(dstart[7:0]), dexp);
    end

    // static duties 0/25/120, ch3 off
    period_in = 8'd100;
    step_in = 8'd5;
    mode_in = {2'b11, 2'b00, 2'b00, 2'b00};
    duty_in = {8'd50, 8'd120, 8'd25, 8'd0};
    measure(0);
    check("p42_pend_start", 32'(pend_start), 1);
    check("p42_hi0", hi[0], 10);
    check("p42_pend_end", 32'(pend_end), 0);
    for (int k = 0; k < 2; k++) begin
      measure(-1);
      check("st_len", len, 100);
      check("st_hi0", hi[0], 0);
      check("st_hi1", hi[1], 25);
      check("st_hi2", hi[2], 100);
      check("st_hi3", hi[3], 0);
      check("st_duty2", 32'(dstart[23:16]), 120);
    end

    // ch2 sawtooth, step 30
    step_in = 8'd30;
    mode_in = {2'b11, 2'b01, 2'b00, 2'b00};
    duty_in = {8'd50, 8'd0, 8'd25, 8'd0};
    measure(0);
    check("p45_hi2", hi[2], 100);
    for (int k = 0; k < 6; k++) begin
      dexp = (30 * k) % 120;
      measure(-1);
      check("saw_hi2", hi[2], dexp);
      check("saw_duty2", 32'(dstart[23:16]), dexp);
      check("saw_hi1", hi[1], 25);
    end

    // period change loaded mid-period, then a load on the boundary edge
    period_in = 8'd50;
    mode_in = {2'b11, 2'b00, 2'b00, 2'b00};
    duty_in = {8'd50, 8'd60, 8'd25, 8'd20};
    measure(40);
    check("p52_len", len, 100);
    check("p52_hi2", hi[2], 60);
    check("p52_pend_mid", 32'(pend_mid), 1);
    check("p52_pend_end", 32'(pend_end), 0);
    duty_in = {8'd50, 8'd60, 8'd25, 8'd10};
    measure(49);
    check("p53_len", len, 50);
    check("p53_hi0", hi[0], 20);
    check("p53_hi2", hi[2], 50);
    check("p53_pend_end", 32'(pend_end), 1);
    measure(-1);
    check("p54_pend_start", 32'(pend_start), 1);
    check("p54_hi0", hi[0], 20);
    measure(-1);
    check("p55_pend_start", 32'(pend_start), 0);
    check("p55_hi0", hi[0], 10);
    check("p55_len", len, 50);

    // enable dropped mid-period
    repeat (20) @(negedge clk);
    check("en_pre_dout1", 32'(dout[1]), 1);
    en = 1'b0;
    @(negedge clk);
    check("en_off_dout", 32'(dout), 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (dout != 0 || cyc_end) bad++;
    end
    check("en_off_quiet", bad, 0);
    en = 1'b1;
    measure(-1);
    check("en_resume_len", len, 50);
    check("en_resume_hi0", hi[0], 10);
    check("en_resume_hi1", hi[1], 25);

    // invalid period while stopped, then running
    en = 1'b0;
    @(negedge clk);
    period_in = 8'd1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("inv_pend", 32'(pending), 0);
    en = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (dout != 0 || cyc_end) bad++;
    end
    check("inv_quiet", bad, 0);
    period_in = 8'd50;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("inv_fix_pend", 32'(pending), 0);
    measure(-1);
    check("inv_fix_len", len, 50);
    check("inv_fix_hi0", hi[0], 10);

    // asynchronous reset between edges
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (18) @(negedge clk);
    check("arst_pre_dout1", 32'(dout[1]), 1);
    check("arst_pre_pend", 32'(pending), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_dout", 32'(dout), 0);
    check("arst_pend", 32'(pending), 0);
    check("arst_cyc", 32'(cyc_end), 0);
    check("arst_duty", duty_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      measure(-1);
      check("arst_len", len, 100);
      check("arst_hi0", hi[0], 5 * k);
      check("arst_hi3", hi[3], 5 * k);
      check("arst_duty0", 32'(dstart[7:0]), 5 * k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
